bp_stream_pump_out: RTL and testbench

Transmit-side stream pump for BedRock memory messages. An FSM (cache engine, CCE, or I/O bridge) produces a message one data beat at a time. This block serializes those beats onto a BedRock stream bus of width `stream_data_width_p`. It replicates the base header on every beat, counts beats against the message size, and asserts `mem_last_o` on the final beat.

---
 rtl/bp_stream_pump_out.sv | 126 ++++++++++++
 tb/tb_bp_stream_pump_out.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_stream_pump_out.sv
// Transmit-side BedRock stream pump: serializes FSM data beats onto a stream bus,
// replicating the first-beat header on every beat and flagging the final beat.
module bp_stream_pump_out #(
   parameter int          stream_data_width_p = 64,
   parameter int          block_width_p       = 512,
   parameter int          paddr_width_p       = 40,
   parameter int          payload_width_p     = 16,
   parameter logic [15:0] stream_mask_p       = 16'h0000,
   localparam int xce_mem_msg_header_width_lp = 11 + paddr_width_p + payload_width_p,
   localparam int stream_words_lp             = block_width_p / stream_data_width_p,
   localparam int data_len_width_lp           = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [xce_mem_msg_header_width_lp-1:0] fsm_base_header_i,
   input  logic [stream_data_width_p-1:0]         fsm_data_i,
   input  logic                                   fsm_v_i,
   output logic                                   fsm_ready_and_o,
   output logic [data_len_width_lp-1:0]           fsm_cnt_o,
   output logic                                   fsm_new_o,
   output logic                                   fsm_done_o,
   output logic [xce_mem_msg_header_width_lp-1:0] mem_header_o,
   output logic [stream_data_width_p-1:0]         mem_data_o,
   output logic                                   mem_v_o,
   output logic                                   mem_last_o,
   input  logic                                   mem_ready_and_i
);

   // Header layout: [3:0] msg_type, [7:4] subop, addr, [2:0] size, payload
   localparam int sizeLsb      = 8 + paddr_width_p;
   localparam int beatBytesLog = $clog2(stream_data_width_p / 8);
   localparam int fifoWidth    = 1 + xce_mem_msg_header_width_lp + stream_data_width_p;
   localparam logic [data_len_width_lp-1:0] cntMax = data_len_width_lp'(stream_words_lp - 1);

   typedef enum logic {e_ready, e_stream} state_e;

   state_e                                 state_q;
   logic [data_len_width_lp-1:0]           cnt_q, cnt_d;
   logic [xce_mem_msg_header_width_lp-1:0] hdr_q;

   logic [xce_mem_msg_header_width_lp-1:0] hdrSel;
   logic [3:0]                             msgType;
   logic [2:0]                             msgSize;
   logic [7:0]                             numStream;
   logic                                   isStream;
   logic                                   lastBeat;
   logic                                   accept;

   logic [fifoWidth-1:0] fifoMem_q [2];
   logic                 wrPtr_q, rdPtr_q;
   logic [1:0]           count_q, count_d;
   logic                 deq;

   // Beat count comes from whichever header is in force: live on the first beat, latched afterwards
   always_comb begin
      hdrSel    = (state_q == e_stream) ? hdr_q : fsm_base_header_i;
      msgType   = hdrSel[3:0];
      msgSize   = hdrSel[sizeLsb +: 3];
      numStream = 8'd1;
      if (int'(msgSize) > beatBytesLog)
         numStream = 8'd1 << (int'(msgSize) - beatBytesLog);
      isStream  = stream_mask_p[msgType] && (numStream > 8'd1) && (stream_words_lp > 1);
      if (state_q == e_ready)
         lastBeat = !isStream;
      else
         lastBeat = (8'(cnt_q) == (numStream - 8'd1)) || (cnt_q == cntMax);
      cnt_d     = (cnt_q == cntMax) ? cnt_q : cnt_q + 1'b1;
   end

   assign fsm_ready_and_o = (count_q != 2'd2);
   assign accept          = fsm_v_i & fsm_ready_and_o;
   assign fsm_done_o      = accept & lastBeat;
   assign fsm_new_o       = (state_q == e_ready) & fsm_v_i;
   assign fsm_cnt_o       = (state_q == e_stream) ? cnt_q : '0;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= e_ready;
         cnt_q   <= '0;
         hdr_q   <= '0;
      end else if (accept) begin
         case (state_q)
            e_ready: begin
               if (!lastBeat) begin
                  hdr_q   <= fsm_base_header_i;
                  cnt_q   <= data_len_width_lp'(1);
                  state_q <= e_stream;
               end
            end
            e_stream: begin
               if (lastBeat) begin
                  cnt_q   <= '0;
                  state_q <= e_ready;
               end else begin
                  cnt_q   <= cnt_d;
               end
            end
            default: state_q <= e_ready;
         endcase
      end
   end

   // Two-entry FIFO: ready depends only on occupancy, so the bus side holds payload stable
   assign mem_v_o = (count_q != 2'd0);
   assign deq     = mem_v_o & mem_ready_and_i;
   assign count_d = count_q + {1'b0, accept} - {1'b0, deq};

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (accept) begin
            fifoMem_q[wrPtr_q] <= {lastBeat, hdrSel, fsm_data_i};
            wrPtr_q            <= ~wrPtr_q;
         end
         if (deq)
            rdPtr_q <= ~rdPtr_q;
         count_q <= count_d;
      end
   end

   assign {mem_last_o, mem_header_o, mem_data_o} = fifoMem_q[rdPtr_q];

endmodule

// File: tb/tb_bp_stream_pump_out.sv
// Scoreboard bench for bp_stream_pump_out: a driver pushes expected bus beats from a
// message-level model, and an independent monitor pops and compares them on each transfer.
module tb_bp_stream_pump_out;

   localparam int DW = 64;
   localparam int BW = 512;
   localparam int PW = 40;
   localparam int YW = 16;
   localparam int HW = 11 + PW + YW;
   localparam logic [15:0] MASK = 16'h000A;

   typedef struct {
      logic          last;
      logic [HW-1:0] hdr;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset_i;
   logic [HW-1:0] fsm_base_header_i;
   logic [DW-1:0] fsm_data_i;
   logic          fsm_v_i;
   logic          fsm_ready_and_o;
   logic [2:0]    fsm_cnt_o;
   logic          fsm_new_o;
   logic          fsm_done_o;
   logic [HW-1:0] mem_header_o;
   logic [DW-1:0] mem_data_o;
   logic          mem_v_o;
   logic          mem_last_o;
   logic          mem_ready_and_i;

   int    testsRun = 0;
   int    failCount = 0;
   int    occ = 0;
   int    readyMode = 0;
   beat_t sbQ[$];

   bp_stream_pump_out #(
      .stream_data_width_p(DW),
      .block_width_p(BW),
      .paddr_width_p(PW),
      .payload_width_p(YW),
      .stream_mask_p(MASK)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .fsm_base_header_i(fsm_base_header_i),
      .fsm_data_i(fsm_data_i),
      .fsm_v_i(fsm_v_i),
      .fsm_ready_and_o(fsm_ready_and_o),
      .fsm_cnt_o(fsm_cnt_o),
      .fsm_new_o(fsm_new_o),
      .fsm_done_o(fsm_done_o),
      .mem_header_o(mem_header_o),
      .mem_data_o(mem_data_o),
      .mem_v_o(mem_v_o),
      .mem_last_o(mem_last_o),
      .mem_ready_and_i(mem_ready_and_i)
   );

   always #5 clk = ~clk;

   // Compares one observed value against the bench's own expectation
   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [HW-1:0] makeHdr(input logic [3:0] msgType, input logic [2:0] size,
                                            input logic [PW-1:0] addr, input logic [YW-1:0] payload);
      return {payload, size, addr, 4'h0, msgType};
   endfunction

   // Message-level model: beats = max(bytes / 8, 1) for masked types, else one beat
   function automatic int refBeats(input logic [3:0] msgType, input logic [2:0] size);
      int n;
      if (!MASK[msgType]) return 1;
      n = (1 << size) / (DW / 8);
      return (n < 1) ? 1 : n;
   endfunction

   task automatic idle(input int n);
      fsm_v_i = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset(input int cycles);
      reset_i = 1'b1;
      fsm_v_i = 1'b0;
      sbQ.delete();
      repeat (cycles) @(posedge clk);
      #1;
      reset_i = 1'b0;
   endtask

   // Offers one whole message; abortAt >= 0 resets the block instead of offering that beat
   task automatic applyStimulus(input logic [3:0] msgType, input logic [2:0] size, input int gapMax,
                                input bit seqData, input int abortAt);
      logic [HW-1:0] hdr;
      int            n;
      hdr = makeHdr(msgType, size, PW'({$urandom(), $urandom()}), YW'($urandom()));
      n   = refBeats(msgType, size);
      for (int b = 0; b < n; b++) begin
         int    waited;
         bit    accepted;
         beat_t e;
         if (b == abortAt) begin
            doReset(1);
            return;
         end
         if (gapMax > 0) idle($urandom_range(0, gapMax));
         fsm_v_i           = 1'b1;
         fsm_base_header_i = (b == 0) ? hdr : HW'({$urandom(), $urandom(), $urandom()});
         fsm_data_i        = seqData ? DW'(b) : {$urandom(), $urandom()};
         waited            = 0;
         accepted          = 1'b0;
         while (!accepted && waited < 200) begin
            @(negedge clk);
            if (fsm_ready_and_o) begin
               checkOutput("fsm_cnt", 128'(fsm_cnt_o), 128'(b));
               checkOutput("fsm_new", 128'(fsm_new_o), 128'(b == 0));
               checkOutput("fsm_done", 128'(fsm_done_o), 128'(b == n - 1));
               e.last = (b == n - 1);
               e.hdr  = hdr;
               e.data = fsm_data_i;
               sbQ.push_back(e);
               accepted = 1'b1;
            end else begin
               checkOutput("cnt_hold", 128'(fsm_cnt_o), 128'(b));
               checkOutput("done_stall", 128'(fsm_done_o), 128'(0));
               waited++;
            end
            @(posedge clk);
            #1;
         end
         if (!accepted) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL accept_timeout: beat %0d never accepted, expected acceptance", b);
         end
      end
   endtask

   // Expected occupancy of the two-entry buffer between FSM and bus
   always @(posedge clk) begin
      if (reset_i) occ = 0;
      else occ = occ + int'(fsm_v_i & fsm_ready_and_o) - int'(mem_v_o & mem_ready_and_i);
   end

   always @(negedge clk) begin
      if (!reset_i) begin
         checkOutput("ready_vs_occ", 128'(fsm_ready_and_o), 128'(occ < 2));
         checkOutput("valid_vs_occ", 128'(mem_v_o), 128'(occ > 0));
         if (mem_v_o && mem_ready_and_i) begin
            if (sbQ.size() == 0) begin
               testsRun++;
               failCount++;
               $display("[TB] FAIL unexpected_beat: got data %0h, expected no beat", mem_data_o);
            end else begin
               beat_t e;
               e = sbQ.pop_front();
               checkOutput("mem_last", 128'(mem_last_o), 128'(e.last));
               checkOutput("mem_header", 128'(mem_header_o), 128'(e.hdr));
               checkOutput("mem_data", 128'(mem_data_o), 128'(e.data));
            end
         end
      end
   end

   initial begin
      int patCnt;
      patCnt = 0;
      mem_ready_and_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            1:       begin mem_ready_and_i = (patCnt % 3 == 0); patCnt++; end
            2:       mem_ready_and_i = ($urandom_range(0, 3) != 0);
            default: mem_ready_and_i = 1'b1;
         endcase
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int waited;
      reset_i           = 1'b1;
      fsm_v_i           = 1'b0;
      fsm_base_header_i = '0;
      fsm_data_i        = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b0;

      @(negedge clk);
      checkOutput("rst_mem_v", 128'(mem_v_o), 128'(0));
      checkOutput("rst_ready", 128'(fsm_ready_and_o), 128'(1));
      checkOutput("rst_cnt", 128'(fsm_cnt_o), 128'(0));
      checkOutput("rst_new_idle", 128'(fsm_new_o), 128'(0));
      checkOutput("rst_done", 128'(fsm_done_o), 128'(0));
      fsm_base_header_i = makeHdr(4'd1, 3'd6, 40'h12345, 16'h1);
      fsm_v_i = 1'b1;
      #1;
      checkOutput("rst_new_valid", 128'(fsm_new_o), 128'(1));
      fsm_v_i = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] 64B write, 8 beats");
      applyStimulus(4'd1, 3'd6, 0, 1'b1, -1);
      $display("[TB] 8B uncached write");
      applyStimulus(4'd3, 3'd3, 0, 1'b0, -1);
      $display("[TB] 64B read, single beat");
      applyStimulus(4'd0, 3'd6, 0, 1'b0, -1);
      $display("[TB] 64B write with bus stalls");
      readyMode = 1;
      applyStimulus(4'd1, 3'd6, 0, 1'b1, -1);
      readyMode = 0;
      $display("[TB] 32B then 64B write back-to-back");
      applyStimulus(4'd1, 3'd5, 0, 1'b0, -1);
      applyStimulus(4'd1, 3'd6, 0, 1'b0, -1);
      idle(4);

      $display("[TB] reset mid-stream");
      applyStimulus(4'd1, 3'd6, 0, 1'b1, 3);
      @(negedge clk);
      checkOutput("mid_rst_mem_v", 128'(mem_v_o), 128'(0));
      @(posedge clk);
      #1;
      applyStimulus(4'd3, 3'd3, 0, 1'b0, -1);
      idle(2);

      $display("[TB] randomized messages");
      readyMode = 2;
      for (int m = 0; m < 40; m++)
         applyStimulus(4'($urandom_range(0, 5)), 3'($urandom_range(0, 6)), 2, 1'b0, -1);
      fsm_v_i   = 1'b0;
      readyMode = 0;

      waited = 0;
      while (sbQ.size() != 0 && waited < 100) begin
         @(posedge clk);
         waited++;
      end
      @(negedge clk);
      checkOutput("drain", 128'(sbQ.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
